charlcd_cmd_sequencer: RTL and testbench
========================================

Name: charlcd_cmd_sequencer

Overview:
- Write-only sequencer for an HD44780-compatible character LCD on an 8-bit bus.
- After reset it runs the power-on wait and the fixed init sequence.
- It then arbitrates the LCD bus between three sources: blink-mode changes, display-shift requests and host character/command writes.
- Each accepted item becomes one timed bus transaction: setup, EN pulse, hold, then the execution wait.

Parameters:
- POWERON_CYC, 150000: LCDCLK cycles waited after reset before the first init command (15 ms at 10 MHz).
- SETUP_CYC, 1: cycles RS/DATA are stable before EN rises.
- EN_CYC, 5: cycles EN is held high.
- HOLD_CYC, 1: cycles RS/DATA are held after EN falls.
- EXEC_CYC, 400: post-transaction wait for normal commands and data.
- CLEAR_CYC, 16000: post-transaction wait for clear (0x01) and home (0x02).

Ports:
- LCDCLK  in  1  block clock; all logic is on the rising edge.
- LCDRESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  host write request.
- REQ_RS  in  1  0 = command, 1 = data.
- REQ_DATA  in  8  command or character byte.
- REQ_READY  out  1  request is accepted when REQ_VALID and REQ_READY are both high on a clock edge.
- BLINK  in  1  level; 1 = cursor blink on.
- SHIFT  in  1  each rising edge requests one display shift-left.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  tied to 0; the block is write-only.
- LCD_EN  out  1  enable strobe.
- LCD_DATA  out  8  data bus.
- INIT_DONE  out  1  set after the 4th init command completes.
- BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- One clock domain, LCDCLK. Reset is asynchronous, active-high, on LCDRESET.
- While reset is asserted, from any state:
  - State goes to POWERON and all counters clear.
  - LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_DATA=0x00, REQ_READY=0, INIT_DONE=0, BUSY=1.
  - blink_applied=0, shift_pending=0, shift_prev=0.
- An in-flight transaction is abandoned, never completed. After release the full init sequence reruns.
- All outputs are registered.
- State machine transitions:
  - POWERON: count POWERON_CYC cycles, then go to SETUP with init command 0.
  - IDLE: select the next item (priority below), then go to SETUP. If nothing is pending, stay in IDLE.
  - SETUP: drive LCD_RS/LCD_DATA for SETUP_CYC cycles with EN=0, then go to ENABLE.
  - ENABLE: EN=1 for EN_CYC cycles, then go to HOLD.
  - HOLD: EN=0, RS/DATA unchanged, for HOLD_CYC cycles, then go to WAIT.
  - WAIT: count CLEAR_CYC if RS=0 and DATA is 0x01 or 0x02, otherwise EXEC_CYC. Then go to IDLE, or to the next init command if init is still in progress.
- Init sequence, all RS=0: 0x38, 0x0C, 0x01, 0x06. INIT_DONE rises on the cycle WAIT of 0x06 exits; it stays high until reset.
- Priority in IDLE (INIT_DONE=1):
  1. Blink mismatch (BLINK != blink_applied): issue 0x0C | BLINK (0x0D when blink is on) and set blink_applied=BLINK.
  2. shift_pending: issue 0x18, clear shift_pending.
  3. Host request.
- SHIFT edge detection:
  - shift_prev samples SHIFT every cycle.
  - A rising edge sets shift_pending in any state, including during init.
  - Further edges while shift_pending is set merge into the one pending shift. No counting.
- BLINK is sampled only in IDLE. Toggling and restoring BLINK while the block is busy produces no command.
- Host handshake and timing:
  - REQ_READY=1 only in IDLE with INIT_DONE=1, no blink mismatch and shift_pending=0.
  - REQ_READY drops in the cycle after acceptance.
  - Request accepted at edge t: RS/DATA valid from t+1, EN rises at t+1+SETUP_CYC, EN falls EN_CYC cycles later.
  - REQ_READY is next possible at t+1+SETUP_CYC+EN_CYC+HOLD_CYC+wait.
- Host requests never preempt or abort a transaction. REQ_VALID may stay high across cycles with no penalty.
- Simultaneous blink mismatch, shift edge and valid request in IDLE: blink goes first, then shift, then host. Each runs as a full transaction.
- LCD_DATA and LCD_RS hold their last value in IDLE. LCD_EN is 0 in every state except ENABLE.
- Counter width is 18 bits, sufficient for all defaults. A parameter value of 0 is treated as 1.

Test Plan (sim parameters POWERON_CYC=20, SETUP_CYC=1, EN_CYC=3, HOLD_CYC=1, EXEC_CYC=8, CLEAR_CYC=30):
- Reset release -> EN stays low for 20 cycles, then 4 EN pulses with DATA 0x38, 0x0C, 0x01, 0x06, all RS=0, 3 cycles wide each. The gap after 0x01 is 30 cycles. INIT_DONE and REQ_READY rise afterwards.
- Host writes RS=1, 0x41 accepted at edge t -> LCD_DATA=0x41 and RS=1 at t+1, EN high t+2..t+4, REQ_READY back high at t+14. A second back-to-back write is accepted exactly then.
- BLINK=1 and one SHIFT edge during init, REQ_VALID held high -> after init: 0x0D, then 0x18, then the host byte, in that order.
- Three SHIFT edges during one host transaction -> exactly one 0x18 is issued.
- LCDRESET pulsed while EN is high mid-transaction -> EN, RS and DATA go to 0 asynchronously. INIT_DONE=0 and the full power-on sequence repeats.
- Host command 0x02 -> 30-cycle wait. Host data 0x02 with RS=1 -> 8-cycle wait.

Source files
------------

// File: rtl/charlcd_cmd_sequencer.sv
// Write-only HD44780 sequencer: power-on wait, fixed init, then blink/shift/host arbitration.
// Every item becomes one timed bus transaction (setup, EN pulse, hold, execution wait).
module charlcd_cmd_sequencer #(
  parameter int POWERON_CYC = 150000,
  parameter int SETUP_CYC   = 1,
  parameter int EN_CYC      = 5,
  parameter int HOLD_CYC    = 1,
  parameter int EXEC_CYC    = 400,
  parameter int CLEAR_CYC   = 16000
) (
  input  logic       LCDCLK,
  input  logic       LCDRESET,
  input  logic       REQ_VALID,
  input  logic       REQ_RS,
  input  logic [7:0] REQ_DATA,
  output logic       REQ_READY,
  input  logic       BLINK,
  input  logic       SHIFT,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA,
  output logic       INIT_DONE,
  output logic       BUSY
);

  // Terminal count of a phase; a length of 0 behaves like 1.
  function automatic logic [17:0] last_of(input int n);
    return (n < 2) ? 18'd0 : 18'(n - 1);
  endfunction

  localparam logic [17:0] PON_LAST   = last_of(POWERON_CYC);
  localparam logic [17:0] SETUP_LAST = last_of(SETUP_CYC);
  localparam logic [17:0] EN_LAST    = last_of(EN_CYC);
  localparam logic [17:0] HOLD_LAST  = last_of(HOLD_CYC);
  localparam logic [17:0] EXEC_LAST  = last_of(EXEC_CYC);
  localparam logic [17:0] CLEAR_LAST = last_of(CLEAR_CYC);

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  typedef enum logic [2:0] {
    S_POWERON, S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] cnt_q, cnt_d, cnt_last;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        blink_applied_q, blink_applied_d;
  logic        shift_pending_q, shift_pending_d;
  logic        shift_prev_q, shift_prev_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        lcd_en_q, lcd_en_d;
  logic        req_ready_q, req_ready_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, busy_d;
  logic        shift_edge, cnt_done, is_clear;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    init_idx_d      = init_idx_q;
    blink_applied_d = blink_applied_q;
    lcd_rs_d        = lcd_rs_q;
    lcd_data_d      = lcd_data_q;
    init_done_d     = init_done_q;
    shift_edge      = SHIFT & ~shift_prev_q;
    shift_prev_d    = SHIFT;
    shift_pending_d = shift_pending_q | shift_edge;
    is_clear        = !lcd_rs_q && (lcd_data_q == 8'h01 || lcd_data_q == 8'h02);

    case (state_q)
      S_POWERON: cnt_last = PON_LAST;
      S_SETUP:   cnt_last = SETUP_LAST;
      S_ENABLE:  cnt_last = EN_LAST;
      S_HOLD:    cnt_last = HOLD_LAST;
      S_WAIT:    cnt_last = is_clear ? CLEAR_LAST : EXEC_LAST;
      default:   cnt_last = 18'd0;
    endcase
    cnt_done = (cnt_q == cnt_last);
    if (state_q != S_IDLE) cnt_d = cnt_done ? 18'd0 : cnt_q + 18'd1;

    case (state_q)
      S_POWERON: if (cnt_done) begin
        state_d    = S_SETUP;
        init_idx_d = 2'd0;
        lcd_rs_d   = 1'b0;
        lcd_data_d = init_cmd(2'd0);
      end
      S_IDLE: begin
        cnt_d = 18'd0;
        // A raised REQ_READY is a promise; honour it before re-arbitrating.
        if (req_ready_q && REQ_VALID) begin
          state_d    = S_SETUP;
          lcd_rs_d   = REQ_RS;
          lcd_data_d = REQ_DATA;
        end else if (BLINK != blink_applied_q) begin
          state_d         = S_SETUP;
          lcd_rs_d        = 1'b0;
          lcd_data_d      = 8'h0C | {7'd0, BLINK};
          blink_applied_d = BLINK;
        end else if (shift_pending_q) begin
          state_d         = S_SETUP;
          lcd_rs_d        = 1'b0;
          lcd_data_d      = 8'h18;
          shift_pending_d = shift_edge;
        end
      end
      S_SETUP:  if (cnt_done) state_d = S_ENABLE;
      S_ENABLE: if (cnt_done) state_d = S_HOLD;
      S_HOLD:   if (cnt_done) state_d = S_WAIT;
      S_WAIT: if (cnt_done) begin
        if (init_done_q) begin
          state_d = S_IDLE;
        end else if (init_idx_q == 2'd3) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d    = S_SETUP;
          init_idx_d = init_idx_q + 2'd1;
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_cmd(init_idx_q + 2'd1);
        end
      end
      default: state_d = S_POWERON;
    endcase

    lcd_en_d    = (state_d == S_ENABLE);
    busy_d      = (state_d != S_IDLE);
    req_ready_d = (state_d == S_IDLE) && init_done_d &&
                  (BLINK == blink_applied_d) && !shift_pending_d;
  end

  always_ff @(posedge LCDCLK or posedge LCDRESET) begin
    if (LCDRESET) begin
      state_q         <= S_POWERON;
      cnt_q           <= '0;
      init_idx_q      <= '0;
      blink_applied_q <= 1'b0;
      shift_pending_q <= 1'b0;
      shift_prev_q    <= 1'b0;
      lcd_rs_q        <= 1'b0;
      lcd_data_q      <= 8'h00;
      lcd_en_q        <= 1'b0;
      req_ready_q     <= 1'b0;
      init_done_q     <= 1'b0;
      busy_q          <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      init_idx_q      <= init_idx_d;
      blink_applied_q <= blink_applied_d;
      shift_pending_q <= shift_pending_d;
      shift_prev_q    <= shift_prev_d;
      lcd_rs_q        <= lcd_rs_d;
      lcd_data_q      <= lcd_data_d;
      lcd_en_q        <= lcd_en_d;
      req_ready_q     <= req_ready_d;
      init_done_q     <= init_done_d;
      busy_q          <= busy_d;
    end
  end

  assign REQ_READY = req_ready_q;
  assign LCD_RS    = lcd_rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_EN    = lcd_en_q;
  assign LCD_DATA  = lcd_data_q;
  assign INIT_DONE = init_done_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_charlcd_cmd_sequencer.sv
// Directed bench for charlcd_cmd_sequencer with shortened timing parameters.
// EN pulses are logged (start cycle, data, rs, width) and compared against hand-computed values.
module tb_charlcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic       blink = 1'b0;
  logic       shift = 1'b0;
  logic       lcd_rs, lcd_rw, lcd_en, init_done, busy;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  charlcd_cmd_sequencer #(
    .POWERON_CYC(20), .SETUP_CYC(1), .EN_CYC(3), .HOLD_CYC(1), .EXEC_CYC(8), .CLEAR_CYC(30)
  ) dut (
    .LCDCLK(clk), .LCDRESET(rst), .REQ_VALID(req_valid), .REQ_RS(req_rs), .REQ_DATA(req_data),
    .REQ_READY(req_ready), .BLINK(blink), .SHIFT(shift), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
    .LCD_EN(lcd_en), .LCD_DATA(lcd_data), .INIT_DONE(init_done), .BUSY(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // EN pulse log, sampled on the falling edge.
  int   q_data[$];
  int   q_rs[$];
  int   q_start[$];
  int   q_width[$];
  logic en_prev = 1'b0;
  int   last_start = 0;

  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      q_start.push_back(cyc);
      q_data.push_back(int'(lcd_data));
      q_rs.push_back(int'(lcd_rs));
      last_start = cyc;
    end
    if (!lcd_en && en_prev) q_width.push_back(cyc - last_start);
    en_prev = lcd_en;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int pick(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_log();
    q_data.delete(); q_rs.delete(); q_start.delete(); q_width.delete();
  endtask

  // Releases reset on a falling edge and checks the whole init sequence.
  task automatic run_init(input bit blink_ev, input int exp_ready);
    int rel, done;
    int exp_d[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    int exp_s[4] = '{21, 34, 47, 82};
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    clear_log();
    done = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (blink_ev && i == 3) begin blink = 1'b1; shift = 1'b1; end
      if (blink_ev && i == 4) shift = 1'b0;
      if (init_done) begin done = cyc - rel; break; end
    end
    check("init_done_cycle", done, 94);
    check("ready_after_init", int'(req_ready), exp_ready);
    check("busy_after_init", int'(busy), 0);
    check("init_pulse_count", q_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("init_data_%0d", i), pick(q_data, i), exp_d[i]);
      check($sformatf("init_rs_%0d", i), pick(q_rs, i), 0);
      check($sformatf("init_start_%0d", i), pick(q_start, i) - rel, exp_s[i]);
      check($sformatf("init_width_%0d", i), pick(q_width, i), 3);
    end
  endtask

  // Holds the request until it is taken; t is the accepting edge number.
  task automatic host_write(input logic rs, input logic [7:0] d, output int t);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    t = -1;
    for (int i = 0; i < 600; i++) begin
      if (req_ready) begin
        @(negedge clk);
        t = cyc;
        req_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("host_accept_in_time", int'(t >= 0), 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int t1, t2, t3, n18;

    idle_cycles(3);
    check("rst_en", int'(lcd_en), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_rw", int'(lcd_rw), 0);
    check("rst_data", int'(lcd_data), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_init_done", int'(init_done), 0);
    check("rst_busy", int'(busy), 1);

    run_init(1'b0, 1);

    // Single host write, then a back-to-back one.
    clear_log();
    host_write(1'b1, 8'h41, t1);
    check("w41_data_next", int'(lcd_data), 8'h41);
    check("w41_rs_next", int'(lcd_rs), 1);
    check("w41_en_next", int'(lcd_en), 0);
    check("w41_ready_drop", int'(req_ready), 0);
    host_write(1'b1, 8'h42, t2);
    check("b2b_accept_gap", t2 - t1, 14);
    idle_cycles(6);
    check("w41_en_start", pick(q_start, 0) - t1, 1);
    check("w41_en_width", pick(q_width, 0), 3);
    check("w42_data", pick(q_data, 1), 8'h42);
    check("w42_rs", pick(q_rs, 1), 1);
    idle_cycles(10);

    // Home command uses the long wait; the same byte as data does not.
    host_write(1'b0, 8'h02, t1);
    host_write(1'b1, 8'h02, t2);
    host_write(1'b1, 8'h43, t3);
    check("cmd02_wait_gap", t2 - t1, 36);
    check("data02_wait_gap", t3 - t2, 14);
    idle_cycles(16);

    // Three SHIFT edges during one transaction merge into one shift.
    clear_log();
    host_write(1'b1, 8'h60, t1);
    for (int i = 0; i < 3; i++) begin
      shift = 1'b1; @(negedge clk);
      shift = 1'b0; @(negedge clk);
    end
    idle_cycles(40);
    check("merge_pulse_count", q_data.size(), 2);
    check("merge_first", pick(q_data, 0), 8'h60);
    n18 = 0;
    foreach (q_data[i]) if (q_data[i] == 8'h18) n18++;
    check("merge_shift_count", n18, 1);
    check("merge_ready_back", int'(req_ready), 1);

    // Reset while EN is high abandons the transaction asynchronously.
    host_write(1'b1, 8'h44, t1);
    for (int i = 0; i < 20 && !lcd_en; i++) @(negedge clk);
    check("pre_reset_en_high", int'(lcd_en), 1);
    #2 rst = 1'b1;
    #1;
    check("async_en", int'(lcd_en), 0);
    check("async_rs", int'(lcd_rs), 0);
    check("async_data", int'(lcd_data), 0);
    check("async_init_done", int'(init_done), 0);
    check("async_busy", int'(busy), 1);
    idle_cycles(2);

    // Full init reruns; BLINK, one SHIFT edge and a held request arrive meanwhile.
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
    run_init(1'b1, 0);
    host_write(1'b1, 8'h55, t1);
    idle_cycles(20);
    check("prio_count", q_data.size(), 7);
    check("prio_blink", pick(q_data, 4), 8'h0D);
    check("prio_shift", pick(q_data, 5), 8'h18);
    check("prio_host", pick(q_data, 6), 8'h55);
    check("prio_host_rs", pick(q_rs, 6), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
